// File: rtl/htc_pkg.sv
// Shared types, sizes and the byte-reversal helper for the hash target checker.
`default_nettype none

package htc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    EMIT = 2'd2,
    HALT = 2'd3
  } htc_state_t;

  localparam int NCHUNK  = 4;
  localparam int CHUNK_W = 64;

  // Byte 0 of the input becomes the most significant byte of the result.
  function automatic logic [255:0] byte_rev256(input logic [255:0] d);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = d[8*(31-i) +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/htc_chunk_cmp.sv
// Unsigned three-way compare of one 64-bit hash chunk against a target chunk.
`default_nettype none

module htc_chunk_cmp
  import htc_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic               lt,
  output logic               gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

`default_nettype wire

// File: rtl/hash_target_check.sv
// ============================================================================
// hash_target_check : pops hash/nonce pairs, compares each hash 64 bits per
// cycle against a programmable target and presents hits on a valid/ready port.
// Optional macro HTC_STOP_ON_FIRST_EN adds found_clear and a HALT state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hash_target_check
  import htc_pkg::*;
#(
  parameter int BYTE_REV    = 1,
  parameter int FOUND_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hash_empty,
  input  logic [255:0]           hash_din,
  input  logic [31:0]            nonce_din,
  output logic                   hash_re,
  input  logic                   target_we,
  input  logic [255:0]           target_din,
  output logic                   found_valid,
  input  logic                   found_ready,
  output logic [31:0]            found_nonce,
  output logic [255:0]           found_hash,
  output logic [31:0]            hash_count,
  output logic [FOUND_CNT_W-1:0] found_count,
  output logic                   busy
`ifdef HTC_STOP_ON_FIRST_EN
  ,
  input  logic                   found_clear
`endif
);

  htc_state_t           state;
  logic [255:0]         target;
  logic [255:0]         t_snap;
  logic [255:0]         h_reg;
  logic [31:0]          nonce_reg;
  logic [1:0]           idx;
  logic [255:0]         hash_in;
  logic [CHUNK_W-1:0]   h_chunk;
  logic [CHUNK_W-1:0]   t_chunk;
  logic                 lt;
  logic                 gt;

  assign hash_in     = (BYTE_REV != 0) ? byte_rev256(hash_din) : hash_din;
  assign hash_re     = !rst && (state == IDLE) && !hash_empty;
  assign found_valid = (state == EMIT);
  assign busy        = (state != IDLE);
  assign found_hash  = h_reg;
  assign found_nonce = nonce_reg;

  // Most significant chunk first.
  always_comb begin
    h_chunk = h_reg[255:192];
    t_chunk = t_snap[255:192];
    case (idx)
      2'd1: begin h_chunk = h_reg[191:128]; t_chunk = t_snap[191:128]; end
      2'd2: begin h_chunk = h_reg[127:64];  t_chunk = t_snap[127:64];  end
      2'd3: begin h_chunk = h_reg[63:0];    t_chunk = t_snap[63:0];    end
      default: ;
    endcase
  end

  htc_chunk_cmp u_cmp (
    .a  (h_chunk),
    .b  (t_chunk),
    .lt (lt),
    .gt (gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      target      <= '1;
      t_snap      <= '0;
      h_reg       <= '0;
      nonce_reg   <= '0;
      idx         <= '0;
      hash_count  <= '0;
      found_count <= '0;
    end else begin
      if (target_we) target <= target_din;
      case (state)
        IDLE: begin
          if (!hash_empty) begin
            h_reg      <= hash_in;
            nonce_reg  <= nonce_din;
            t_snap     <= target;
            hash_count <= hash_count + 32'd1;
            idx        <= '0;
            state      <= CMP;
          end
        end
        CMP: begin
          // Equality on the last chunk counts as meeting the target.
          if (lt || (!gt && idx == 2'(NCHUNK-1))) begin
            state <= EMIT;
            if (found_count != '1) found_count <= found_count + FOUND_CNT_W'(1);
          end else if (gt) begin
            state <= IDLE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        EMIT: begin
          if (found_ready) begin
`ifdef HTC_STOP_ON_FIRST_EN
            state <= HALT;
`else
            state <= IDLE;
`endif
          end
        end
        HALT: begin
`ifdef HTC_STOP_ON_FIRST_EN
          if (found_clear) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
